// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller.
// The master drives the ID/EX observations; the slave returns the stall, flush and multiplier controls.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned RW = 5
);
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic [RW-1:0] ex_rw;
  logic          ex_reg_we;
  logic          ex_mem_to_reg;
  logic          ex_mul;
  logic          ex_redirect;

  logic          pc_stall;
  logic          if_id_stall;
  logic          id_ex_stall;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          ex_mem_flush;
  logic          mul_start;
  logic          mul_done;
  logic          mul_busy;
  logic [31:0]   stall_count;
  logic [31:0]   flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rw, ex_reg_we, ex_mem_to_reg, ex_mul, ex_redirect,
    input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           ex_mem_flush, mul_start, mul_done, mul_busy, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rw, ex_reg_we, ex_mem_to_reg, ex_mul, ex_redirect,
    output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
           ex_mem_flush, mul_start, mul_done, mul_busy, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// multi-cycle multiply occupancy of EX, EX-resolved redirects and hazard counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned RW         = 5
) (
  input  logic              clock,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned CW    = $clog2(MUL_CYCLES + 1);
  localparam bit          MULTI = (MUL_CYCLES > 1);

  typedef enum logic {RUN, MUL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   stall_q, flush_q;

  logic [RW-1:0] ex_rw;
  logic          load_use;
  logic          pc_stall, if_id_stall, id_ex_stall;
  logic          if_id_flush, id_ex_flush, ex_mem_flush;
  logic          mul_start, mul_done, mul_busy;

  assign ex_rw = bus.ex_rw;

  assign load_use = bus.ex_mem_to_reg && bus.ex_reg_we && (ex_rw != '0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == ex_rw)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == ex_rw)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mul_start    = 1'b0;
    mul_done     = 1'b0;
    mul_busy     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.ex_mul && MULTI) begin
          mul_start    = 1'b1;
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
          cnt_d        = CW'(MUL_CYCLES - 1);
          state_d      = MUL;
        end else begin
          // A single-cycle multiply completes in place and does not block redirect/load-use.
          if (bus.ex_mul) begin
            mul_start = 1'b1;
            mul_done  = 1'b1;
          end
          if (bus.ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
      end
      MUL: begin
        mul_busy = 1'b1;
        if (cnt_q > CW'(1)) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
          cnt_d        = cnt_q - CW'(1);
        end else begin
          mul_done = 1'b1;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Reset masks every control so a multiply caught mid-flight never reports done.
    if (reset) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mul_start    = 1'b0;
      mul_done     = 1'b0;
      mul_busy     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_stall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (if_id_flush && (flush_q != '1)) flush_q <= flush_q + 32'd1;
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.if_id_stall  = if_id_stall;
  assign bus.id_ex_stall  = id_ex_stall;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mul_start    = mul_start;
  assign bus.mul_done     = mul_done;
  assign bus.mul_busy     = mul_busy;
  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;
endmodule
